// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified I/D SRAM arbiter.
// SRAM strobe levels match the SP_SRAM macro (active-low).
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_I    = 2'd1,
    REQ_D    = 2'd2
  } req_owner_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = $clog2(WORD_BYTES);

  localparam logic CSN_ACTIVE = 1'b0;
  localparam logic CSN_IDLE   = 1'b1;
  localparam logic WEN_WRITE  = 1'b0;
  localparam logic WEN_READ   = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and SRAM pins of the unified arbiter.
// master: core ports plus SRAM model; slave: the arbiter.
interface unified_mem_arbiter_if #(
  parameter int AWIDTH = 10
);
  logic              I_REQ;
  logic [11:0]       I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;

  logic              D_REQ;
  logic              D_WEN;
  logic [3:0]        D_BE;
  logic [11:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;

  logic              MEM_CSN;
  logic              MEM_WEN;
  logic [3:0]        MEM_BE;
  logic [AWIDTH-1:0] MEM_ADDR;
  logic [31:0]       MEM_DI;
  logic [31:0]       MEM_DOUT;

  modport master (
    output I_REQ, I_ADDR,
    input  I_GNT, I_RVALID, I_RDATA,
    output D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI,
    output MEM_DOUT
  );

  modport slave (
    input  I_REQ, I_ADDR,
    output I_GNT, I_RVALID, I_RDATA,
    input  D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI,
    input  MEM_DOUT
  );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive contested D wins.
// o_force tells the arbiter to let fetch through.
module arb_streak_counter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_force
);

  localparam int CW = $clog2(MAX_D_STREAK + 1);
  localparam logic [CW-1:0] MAXV = CW'(MAX_D_STREAK);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RSTn || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAXV)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_force = (r_cnt == MAXV);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between fetch and data ports.
// D wins contention until a bounded streak forces an I grant.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AWIDTH       = 10,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  unified_mem_arbiter_if.slave bus
);

  logic        w_both;
  logic        w_force_i;
  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_unused;
  req_owner_e  w_owner;

  logic        r_pend;
  req_owner_e  r_owner;

  assign w_both = bus.I_REQ & bus.D_REQ;

  always_comb begin
    w_owner = REQ_NONE;
    if (RSTn) begin
      unique case (1'b1)
        w_both && w_force_i:        w_owner = REQ_I;
        w_both && !w_force_i:       w_owner = REQ_D;
        bus.I_REQ && !bus.D_REQ:    w_owner = REQ_I;
        bus.D_REQ && !bus.I_REQ:    w_owner = REQ_D;
        default:                    w_owner = REQ_NONE;
      endcase
    end
  end

  assign w_gnt_i = (w_owner == REQ_I);
  assign w_gnt_d = (w_owner == REQ_D);

  arb_streak_counter #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_inc   (w_both & w_gnt_d),
    .i_clr   (w_gnt_i | ~bus.I_REQ),
    .o_force (w_force_i)
  );

  assign bus.I_GNT = w_gnt_i;
  assign bus.D_GNT = w_gnt_d;

  // Byte-lane bits and bits beyond the SRAM depth are dropped (wrap).
  assign bus.MEM_CSN  = (w_gnt_i | w_gnt_d) ? CSN_ACTIVE : CSN_IDLE;
  assign bus.MEM_WEN  = w_gnt_d ? bus.D_WEN : WEN_READ;
  assign bus.MEM_BE   = w_gnt_d ? bus.D_BE : 4'b0000;
  assign bus.MEM_DI   = bus.D_WDATA;
  assign bus.MEM_ADDR = w_gnt_d
    ? bus.D_ADDR[AWIDTH+ADDR_LSB-1:ADDR_LSB]
    : bus.I_ADDR[AWIDTH+ADDR_LSB-1:ADDR_LSB];

  assign w_unused = ^{bus.I_ADDR, bus.D_ADDR};

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_pend  <= 1'b0;
      r_owner <= REQ_NONE;
    end else begin
      r_pend  <= w_gnt_i | (w_gnt_d & (bus.D_WEN == WEN_READ));
      r_owner <= w_owner;
    end
  end

  // Gated by RSTn so a read in flight at reset never returns.
  assign bus.I_RVALID = RSTn & r_pend & (r_owner == REQ_I);
  assign bus.D_RVALID = RSTn & r_pend & (r_owner == REQ_D);
  assign bus.I_RDATA  = bus.MEM_DOUT;
  assign bus.D_RDATA  = bus.MEM_DOUT;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Random and directed checks of the unified arbiter
// against a cycle-level reference model.
module tb_unified_mem_arbiter;

  localparam int AW   = 10;
  localparam int MAXS = 4;
  localparam int WORDS = 1 << AW;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  always #5 CLK = ~CLK;

  unified_mem_arbiter_if #(.AWIDTH(AW)) bus();

  unified_mem_arbiter #(
    .AWIDTH       (AW),
    .MAX_D_STREAK (MAXS)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] gold [WORDS];
  int          streak;
  logic        exp_iv, exp_dv;
  logic [31:0] exp_rd;
  logic        i_hold, d_hold;
  logic [31:0] last_i, last_d;

  function automatic logic [31:0] seed_word(input int i);
    if (i == 1) return 32'h00c4a433;
    return (32'(i) * 32'h9e3779b9) ^ 32'h5a5a0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SRAM model: 1-cycle read latency, byte-masked writes
  logic [31:0] sram [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) sram[i] = seed_word(i);
    bus.MEM_DOUT = '0;
    forever begin
      @(posedge CLK);
      if (bus.MEM_CSN == 1'b0) begin
        if (bus.MEM_WEN == 1'b0) begin
          for (int b = 0; b < 4; b++)
            if (bus.MEM_BE[b])
              sram[bus.MEM_ADDR][8*b +: 8] = bus.MEM_DI[8*b +: 8];
        end else begin
          bus.MEM_DOUT <= sram[bus.MEM_ADDR];
        end
      end
    end
  end

  task automatic step(input logic rst, input logic ir,
                      input logic [11:0] ia, input logic dr,
                      input logic dw, input logic [3:0] be,
                      input logic [11:0] da, input logic [31:0] wd);
    logic gi, gd, any;
    logic [9:0] wa;
    @(posedge CLK);
    #1;
    RSTn        = rst;
    bus.I_REQ   = ir;
    bus.I_ADDR  = ia;
    bus.D_REQ   = dr;
    bus.D_WEN   = dw;
    bus.D_BE    = be;
    bus.D_ADDR  = da;
    bus.D_WDATA = wd;
    gi = 1'b0;
    gd = 1'b0;
    if (rst) begin
      if (ir && dr) begin
        if (streak == MAXS) gi = 1'b1;
        else gd = 1'b1;
      end else begin
        gi = ir;
        gd = dr;
      end
    end
    any = gi | gd;
    wa  = gd ? da[11:2] : ia[11:2];
    @(negedge CLK);
    check("i_gnt", 32'(bus.I_GNT), 32'(gi));
    check("d_gnt", 32'(bus.D_GNT), 32'(gd));
    check("mem_csn", 32'(bus.MEM_CSN), 32'(!any));
    check("i_rvalid", 32'(bus.I_RVALID), 32'(rst && exp_iv));
    check("d_rvalid", 32'(bus.D_RVALID), 32'(rst && exp_dv));
    if (rst && exp_iv) check("i_rdata", bus.I_RDATA, exp_rd);
    if (rst && exp_dv) check("d_rdata", bus.D_RDATA, exp_rd);
    if (bus.I_RVALID) last_i = bus.I_RDATA;
    if (bus.D_RVALID) last_d = bus.D_RDATA;
    if (any) check("mem_addr", 32'(bus.MEM_ADDR), 32'(wa));
    if (gi) begin
      check("mem_wen_i", 32'(bus.MEM_WEN), 32'd1);
      check("mem_be_i", 32'(bus.MEM_BE), 32'd0);
    end
    if (gd) begin
      check("mem_wen_d", 32'(bus.MEM_WEN), 32'(dw));
      check("mem_be_d", 32'(bus.MEM_BE), 32'(be));
      if (!dw) check("mem_di", bus.MEM_DI, wd);
    end
    if (!rst) check("mem_wen_rst", 32'(bus.MEM_WEN), 32'd1);
    // model state advanced for the coming edge
    exp_iv = gi;
    exp_dv = gd && dw;
    if (gi || (gd && dw)) exp_rd = gold[wa];
    if (gd && !dw)
      for (int b = 0; b < 4; b++)
        if (be[b]) gold[wa][8*b +: 8] = wd[8*b +: 8];
    if (!rst || gi || !ir) streak = 0;
    else if (ir && dr && streak < MAXS) streak++;
    i_hold = rst && ir && !gi;
    d_hold = rst && dr && !gd;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 12'h0, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
  endtask

  logic [9:0]  seq;
  logic        r_rst, r_ir, r_dr, r_dw;
  logic [11:0] r_ia, r_da;
  logic [3:0]  r_be;
  logic [31:0] r_wd;

  initial begin
    for (int i = 0; i < WORDS; i++) gold[i] = seed_word(i);
    streak = 0;
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    exp_rd = '0;
    last_i = '0;
    last_d = '0;
    bus.I_REQ = 1'b0; bus.I_ADDR = '0;
    bus.D_REQ = 1'b0; bus.D_WEN = 1'b1; bus.D_BE = '0;
    bus.D_ADDR = '0;  bus.D_WDATA = '0;

    // reset with both requesting: nothing granted
    step(1'b0, 1'b1, 12'h004, 1'b1, 1'b1, 4'hf, 12'h008, 32'h0);
    step(1'b0, 1'b1, 12'h004, 1'b1, 1'b1, 4'hf, 12'h008, 32'h0);
    idle(1'b1);

    // fetch-only stream from word 1
    step(1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
    check("fetch_addr", 32'(bus.MEM_ADDR), 32'd1);
    step(1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
    step(1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
    idle(1'b1);
    check("fetch_data", last_i, 32'h00c4a433);

    // word write, read back; then byte write, read back
    step(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 4'b1111, 12'h100, 32'h000002dd);
    step(1'b1, 1'b0, 12'h0, 1'b1, 1'b1, 4'b1111, 12'h100, 32'h0);
    idle(1'b1);
    check("wr_rd", last_d, 32'h000002dd);
    step(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001, 12'h100, 32'h000000cc);
    step(1'b1, 1'b0, 12'h0, 1'b1, 1'b1, 4'b1111, 12'h100, 32'h0);
    idle(1'b1);
    check("byte_wr", last_d, 32'h000002cc);

    // sustained contention
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 12'h010, 1'b1, 1'b1, 4'hf, 12'h100, 32'h0);
      seq = {seq[8:0], bus.I_GNT};
    end
    check("contend_seq", 32'(seq), 32'(10'b0000100001));
    idle(1'b1);

    // reset while a D read is in flight
    step(1'b1, 1'b0, 12'h0, 1'b1, 1'b1, 4'hf, 12'h100, 32'h0);
    step(1'b0, 1'b1, 12'h010, 1'b1, 1'b1, 4'hf, 12'h100, 32'h0);
    check("rst_csn", 32'(bus.MEM_CSN), 32'd1);
    check("rst_drv", 32'(bus.D_RVALID), 32'd0);
    step(1'b1, 1'b1, 12'h010, 1'b1, 1'b1, 4'hf, 12'h100, 32'h0);
    check("post_rst_d", 32'(bus.D_GNT), 32'd1);
    idle(1'b1);

    // address mapping at the SRAM edges
    step(1'b1, 1'b1, 12'hffc, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
    check("wrap_top", 32'(bus.MEM_ADDR), 32'h3ff);
    step(1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
    check("wrap_zero", 32'(bus.MEM_ADDR), 32'h000);
    step(1'b1, 1'b1, 12'h002, 1'b0, 1'b1, 4'h0, 12'h0, 32'h0);
    check("low_bits", 32'(bus.MEM_ADDR), 32'h000);
    idle(1'b1);

    // random traffic with request hold and occasional reset
    r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b1;
    r_ia = '0; r_da = '0; r_be = '0; r_wd = '0;
    for (int k = 0; k < 500; k++) begin
      r_rst = ($urandom_range(0, 59) != 0);
      if (!i_hold) begin
        r_ir = ($urandom_range(0, 2) != 0);
        r_ia = 12'($urandom);
      end
      if (!d_hold) begin
        r_dr = ($urandom_range(0, 2) != 0);
        r_dw = 1'($urandom_range(0, 1));
        r_be = 4'($urandom);
        r_da = {4'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)};
        r_wd = $urandom;
      end
      step(r_rst, r_ir, r_ia, r_dr, r_dw, r_be, r_da, r_wd);
    end
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM (SP_SRAM convention) between the core's instruction-fetch port and data port, so a unified I/D memory can replace the split I-mem/D-mem.
- Data side wins by default. A starvation guard grants fetch after a bounded streak of data wins.
- Read data returns with the fixed 1-cycle SRAM latency, steered to the requester that issued the read.

Parameters:
- AWIDTH, 10, SRAM word-address width; MEM_ADDR = requester byte address [AWIDTH+1:2].
- MAX_D_STREAK, 4, consecutive contested cycles D may win before I is forced through (must be >= 1).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- I_REQ  in  1  fetch request; held with I_ADDR until I_GNT.
- I_ADDR  in  12  fetch byte address.
- I_GNT  out  1  fetch accepted this cycle (combinational).
- I_RVALID  out  1  I_RDATA valid (cycle after I_GNT).
- I_RDATA  out  32  fetched word.
- D_REQ  in  1  data request; held with D_* until D_GNT.
- D_WEN  in  1  active-low write enable (0 = write, 1 = read).
- D_BE  in  4  byte enables, passed through unmodified.
- D_ADDR  in  12  data byte address.
- D_WDATA  in  32  store data.
- D_GNT  out  1  data access accepted this cycle (combinational).
- D_RVALID  out  1  D_RDATA valid (cycle after a granted read).
- D_RDATA  out  32  load word.
- MEM_CSN  out  1  SRAM chip select, active-low.
- MEM_WEN  out  1  SRAM write enable, active-low.
- MEM_BE  out  4  SRAM byte enables.
- MEM_ADDR  out  AWIDTH  SRAM word address.
- MEM_DI  out  32  SRAM write data.
- MEM_DOUT  in  32  SRAM read data.

Behaviour:
- Reset: while RSTn=0 at a rising edge, clear the streak counter, rd_owner and rd_pending.
  - Outputs held during reset: I_GNT=D_GNT=0, I_RVALID=D_RVALID=0, MEM_CSN=1, MEM_WEN=1.
  - A read in flight when reset asserts is dropped: no RVALID after reset releases.
- Arbitration (combinational, per cycle, only when RSTn=1):
  - Neither requesting: no grant, MEM_CSN=1.
  - One requesting: that side is granted.
  - Both requesting: D wins unless streak == MAX_D_STREAK, in which case I wins.
- Streak counter:
  - Increments (saturating at MAX_D_STREAK) on each cycle where both request and D wins.
  - Clears on any I grant and on any cycle with I_REQ=0.
- Memory drive on grant:
  - MEM_CSN=0.
  - MEM_ADDR = granted address[AWIDTH+1:2].
  - I grant: MEM_WEN=1, MEM_BE=4'b0000.
  - D grant: MEM_WEN=D_WEN, MEM_BE=D_BE, MEM_DI=D_WDATA.
- Address bits [1:0] are ignored, and bits above AWIDTH+1 are ignored, i.e. the address wraps modulo the SRAM size.
- Read return:
  - Register rd_pending (granted read) and rd_owner (I/D) at the grant edge.
  - Next cycle, assert the owner's RVALID for exactly one cycle.
  - Drive both RDATA outputs from MEM_DOUT.
  - A D write never produces D_RVALID.
- Throughput: one access per cycle, back-to-back. A new grant may coincide with the RVALID of the previous read.
- RDATA outputs are don't-care when RVALID=0.

Decomposition:
- Shared package: REQ_NONE/REQ_I/REQ_D owner encoding, WORD_BYTES=4, and the active-low CSN/WEN constants common with SP_SRAM.
- One natural sub-module, arb_streak_counter: saturating counter with clear, parameterised by MAX_D_STREAK. It produces the force_i flag.

Test Plan:
- I-only, I_REQ=1, I_ADDR=0x004 for 3 cycles, SRAM preloaded word1=0x00c4a433 → I_GNT every cycle, MEM_ADDR=1, I_RVALID one cycle later with I_RDATA=0x00c4a433, no D_RVALID.
- D write then read: D_WEN=0, D_ADDR=0x100, D_BE=4'b1111, D_WDATA=0x000002dd; next cycle read same address → D_GNT both cycles, no D_RVALID after the write, D_RVALID=1 with D_RDATA=0x000002dd two cycles after the write grant.
- Byte write 0xcc with D_BE=4'b0001 to 0x100 after 0x2dd, then word read → D_RDATA=0x000002cc.
- Contention, MAX_D_STREAK=4, I_REQ and D_REQ held high 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I; each I_RVALID follows its I grant by 1 cycle.
- Reset mid-read: D read granted at cycle n, RSTn=0 sampled at cycle n+1 → D_RVALID stays 0, MEM_CSN=1, streak=0; after release, first contested cycle grants D.
- Address wrap, AWIDTH=10: I_ADDR=0xFFC vs 0x000 (unwrapped; wraps only when AWIDTH<10) → MEM_ADDR=0x3FF vs 0x000 respectively; I_ADDR=0x002 → MEM_ADDR=0 (low bits ignored).
